leading_zero_pipe: RTL

LEADING_ZERO_PIPE -- requirements
Module: leading_zero_pipe

---
 rtl/leading_zero_pipe.sv | 131 +++++++++++++
 1 files changed

// File: rtl/leading_zero_pipe.sv
// Two-stage leading-zero counter that turns an adder result into a
// normalisation shift amount and direction for the downstream shifter.
// Stage 1 splits the (1-padded) significand into byte groups and records a
// per-group zero flag and local leading-zero count; stage 2 picks the first
// non-zero group and forms the final count.
module leading_zero_pipe #(
  parameter int unsigned SWR = 26,
  parameter int unsigned EWR = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_i,
  input  logic [SWR-1:0] Data_i,
  input  logic           Add_overflow_i,
  output logic [EWR-1:0] Shift_Value_o,
  output logic           FSM_left_right_o,
  output logic           Zero_flag_o,
  output logic           load_o
);

  localparam int unsigned NumGroups = (SWR + 7) / 8;
  localparam int unsigned PadW      = NumGroups * 8;

  // Leading zeros of an 8-bit group; only meaningful for a non-zero group.
  function automatic logic [2:0] lzc8(input logic [7:0] v);
    logic [2:0] r;
    r = 3'd0;
    for (int b = 0; b < 8; b++) begin
      if (v[b]) r = 3'(7 - b);
    end
    return r;
  endfunction

  logic [PadW-1:0]                padded;
  logic [PadW-1:0]                data_mask;
  logic [NumGroups-1:0]           grp_zero_d;
  logic [NumGroups-1:0][2:0]      grp_lzc_d;

  logic                           v1_q;
  logic                           ovf_q;
  logic [NumGroups-1:0]           grp_zero_q;
  logic [NumGroups-1:0][2:0]      grp_lzc_q;

  logic                           found_s2;
  logic [EWR-1:0]                 cnt_s2;
  logic [EWR-1:0]                 shift_d, shift_q;
  logic                           dir_d, dir_q;
  logic                           zero_d, zero_q;
  logic                           v2_q;

  // Pad the LSB end with 1s so the lowest group's count stops at the pad;
  // zero flags look at real data bits only, so pad never reads as data.
  always_comb begin
    padded                   = '1;
    padded[PadW-1 -: SWR]    = Data_i;
    data_mask                = '0;
    data_mask[PadW-1 -: SWR] = '1;
    grp_zero_d               = '0;
    grp_lzc_d                = '0;
    for (int g = 0; g < NumGroups; g++) begin
      grp_zero_d[g] = ~|(padded[PadW-1-8*g -: 8] & data_mask[PadW-1-8*g -: 8]);
      grp_lzc_d[g]  = lzc8(padded[PadW-1-8*g -: 8]);
    end
  end

  // Stage 1: valid follows load_i every cycle, data only on load.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v1_q       <= 1'b0;
      ovf_q      <= 1'b0;
      grp_zero_q <= '0;
      grp_lzc_q  <= '0;
    end else begin
      v1_q <= load_i;
      if (load_i) begin
        ovf_q      <= Add_overflow_i;
        grp_zero_q <= grp_zero_d;
        grp_lzc_q  <= grp_lzc_d;
      end
    end
  end

  // First non-zero group from the MSB end gives 8*g + local count.
  always_comb begin
    found_s2 = 1'b0;
    cnt_s2   = '0;
    for (int g = 0; g < NumGroups; g++) begin
      if (!found_s2 && !grp_zero_q[g]) begin
        found_s2 = 1'b1;
        cnt_s2   = EWR'(8 * g) + EWR'(grp_lzc_q[g]);
      end
    end
  end

  // Output selection: overflow beats zero beats normal left shift.
  always_comb begin
    shift_d = cnt_s2;
    dir_d   = 1'b1;
    zero_d  = 1'b0;
    if (ovf_q) begin
      shift_d = EWR'(1);
      dir_d   = 1'b0;
    end else if (!found_s2) begin
      shift_d = '0;
      zero_d  = 1'b1;
    end
  end

  // Stage 2: outputs update only on a stage-1 valid, otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      v2_q    <= 1'b0;
      shift_q <= '0;
      dir_q   <= 1'b0;
      zero_q  <= 1'b0;
    end else begin
      v2_q <= v1_q;
      if (v1_q) begin
        shift_q <= shift_d;
        dir_q   <= dir_d;
        zero_q  <= zero_d;
      end
    end
  end

  assign Shift_Value_o    = shift_q;
  assign FSM_left_right_o = dir_q;
  assign Zero_flag_o      = zero_q;
  assign load_o           = v2_q;

endmodule
